// File: rtl/ws2812_driver.sv
// ws2812_driver: serialises one GRB colour triple per frame onto a WS2812 NRZ line
module ws2812_driver #(
  parameter int T0H          = 4,
  parameter int T1H          = 8,
  parameter int BIT_CYCLES   = 12,
  parameter int LATCH_CYCLES = 500
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] red,
  input  logic [7:0] green,
  input  logic [7:0] blue,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       dout
);
  localparam int CMAX = (BIT_CYCLES > LATCH_CYCLES) ? BIT_CYCLES : LATCH_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] BIT_HIGH = 2'd1;
  localparam logic [1:0] BIT_LOW  = 2'd2;
  localparam logic [1:0] LATCH    = 2'd3;
  logic [1:0]    state;
  logic [23:0]   sr;
  logic [4:0]    idx;
  logic [CW-1:0] cnt;
  logic [CW-1:0] th;
  logic [CW-1:0] last;
  logic          end_st;
  assign busy = state != IDLE;
  // high width follows the current MSB; last is the final counter value of the current state
  always_comb begin
    th     = sr[23] ? CW'(T1H) : CW'(T0H);
    last   = state == BIT_HIGH ? th - 1'b1 :
             state == BIT_LOW  ? CW'(BIT_CYCLES) - th - 1'b1 : CW'(LATCH_CYCLES - 1);
    end_st = cnt == last;
  end
  // frame sequencer; dout is registered from the next state so edges land exactly on state changes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      sr    <= '0;
      idx   <= '0;
      cnt   <= '0;
      dout  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          sr    <= {green, red, blue};
          idx   <= '0;
          cnt   <= '0;
          dout  <= 1'b1;
          state <= BIT_HIGH;
        end
        BIT_HIGH: if (end_st) begin
          cnt   <= '0;
          dout  <= 1'b0;
          state <= BIT_LOW;
        end else cnt <= cnt + 1'b1;
        BIT_LOW: if (end_st) begin
          cnt   <= '0;
          sr    <= {sr[22:0], 1'b0};
          idx   <= idx + 1'b1;
          dout  <= idx != 5'd23;
          state <= idx == 5'd23 ? LATCH : BIT_HIGH;
        end else cnt <= cnt + 1'b1;
        LATCH: if (end_st) begin
          cnt   <= '0;
          done  <= 1'b1;
          state <= IDLE;
        end else cnt <= cnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ws2812_driver.sv
// tb_ws2812_driver: directed checks of frame timing, capture, back-to-back, reset and parameters
module tb_ws2812_driver;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [7:0] red = '0, green = '0, blue = '0;
  logic start = 1'b0, start2 = 1'b0;
  logic busy, done, dout, busy2, done2, dout2;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  ws2812_driver dut (
    .clk(clk), .reset(reset), .red(red), .green(green), .blue(blue),
    .start(start), .busy(busy), .done(done), .dout(dout)
  );

  ws2812_driver #(.T0H(2), .T1H(5), .BIT_CYCLES(7), .LATCH_CYCLES(3)) dut2 (
    .clk(clk), .reset(reset), .red(red), .green(green), .blue(blue),
    .start(start2), .busy(busy2), .done(done2), .dout(dout2)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // one frame from start; compares dout cycle by cycle against the bit-timing model,
  // decodes the received word from pulse widths and checks done/busy at the end cycle
  task automatic run_frame(input string tag, input bit which, input logic [23:0] grb,
                           input int t0, input int t1, input int bc, input int lc,
                           input bit hold, input bit disturb);
    int len = 24 * bc + lc;
    int errs = 0, busy_err = 0, hi = 0, k, pos;
    logic [23:0] rx = '0;
    logic d, b, dn, e;
    @(negedge clk);
    if (which) start2 = 1'b1; else start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (!hold) begin start = 1'b0; start2 = 1'b0; end
    for (int i = 1; i <= len + 1; i++) begin
      d  = which ? dout2 : dout;
      b  = which ? busy2 : busy;
      dn = which ? done2 : done;
      if (i <= len) begin
        k   = (i - 1) / bc;
        pos = (i - 1) % bc;
        e   = (k < 24) && (pos < (grb[23-k] ? t1 : t0));
        if (d !== e) errs++;
        if (b !== 1'b1 || dn !== 1'b0) busy_err++;
        if (k < 24 && d === 1'b1) hi++;
        if (k < 24 && pos == bc - 1) begin
          rx = {rx[22:0], (hi > t0) ? 1'b1 : 1'b0};
          hi = 0;
        end
      end
      if (disturb) begin
        if (i == 20) red = 8'h00;
        if (i == 50 || i == 300) start = 1'b1;
        if (i == 51 || i == 301) start = 1'b0;
      end
      if (i <= len) @(negedge clk);
    end
    check({tag, "_dout"}, errs, 0);
    check({tag, "_word"}, {8'h0, rx}, {8'h0, grb});
    check({tag, "_busy_in_frame"}, busy_err, 0);
    check({tag, "_done_at_end"}, {31'h0, dn}, 1);
    check({tag, "_busy_at_end"}, {31'h0, b}, 0);
  endtask

  initial begin
    int cnt, low, bad;
    repeat (3) @(negedge clk);
    check("rst_dout", {29'h0, dout, dout2, 1'b0}, 0);
    check("rst_busy", {30'h0, busy, busy2}, 0);
    check("rst_done", {30'h0, done, done2}, 0);
    reset = 1'b0;
    @(negedge clk);

    green = 8'h00; red = 8'hFF; blue = 8'hA5;
    run_frame("mixed", 1'b0, 24'h00FFA5, 4, 8, 12, 500, 1'b0, 1'b0);

    run_frame("ignore", 1'b0, 24'h00FFA5, 4, 8, 12, 500, 1'b0, 1'b1);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0) bad++;
    end
    check("ignore_no_extra_frame", bad, 0);
    red = 8'hFF;

    run_frame("b2b", 1'b0, 24'h00FFA5, 4, 8, 12, 500, 1'b1, 1'b0);
    cnt = 0; low = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      cnt++;
      if (done === 1'b1) break;
      if (busy !== 1'b1) low++;
    end
    check("b2b_period", cnt, 789);
    check("b2b_busy_low", low, 0);
    check("b2b_busy_at_done", {31'h0, busy}, 0);
    start = 1'b0;
    cnt = 0;
    while (busy !== 1'b0 && cnt < 1000) begin
      @(negedge clk);
      cnt++;
    end
    check("b2b_third_frame_ends", {31'h0, busy}, 0);

    green = 8'hFF; red = 8'hFF; blue = 8'hFF;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (122) @(negedge clk);
    check("midrst_pre_dout", {31'h0, dout}, 1);
    reset = 1'b1;
    #1;
    check("midrst_dout", {31'h0, dout}, 0);
    check("midrst_busy", {31'h0, busy}, 0);
    check("midrst_done", {31'h0, done}, 0);
    @(negedge clk);
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0) bad++;
    end
    check("midrst_no_done", bad, 0);
    green = 8'h12; red = 8'h34; blue = 8'h56;
    run_frame("after_rst", 1'b0, 24'h123456, 4, 8, 12, 500, 1'b0, 1'b0);

    green = 8'hFF; red = 8'hFF; blue = 8'hFF;
    run_frame("ones", 1'b0, 24'hFFFFFF, 4, 8, 12, 500, 1'b0, 1'b0);
    green = 8'h00; red = 8'h00; blue = 8'h00;
    run_frame("zeros", 1'b0, 24'h000000, 4, 8, 12, 500, 1'b0, 1'b0);

    green = 8'h00; red = 8'hFF; blue = 8'hA5;
    run_frame("param", 1'b1, 24'h00FFA5, 2, 5, 7, 3, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
